// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem sequencer that feeds a single-cycle datapath.
// Defining SEQ_PERF_COUNTERS_EN adds the cycle_cnt/retire_cnt performance counters.
module instr_sequencer #(
   parameter int unsigned ADDR_W        = 8,
   parameter int unsigned PC_RESET      = 0,
   parameter int unsigned MEM_WAIT      = 1,
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instruction,
   output logic              exec_en,
   output logic              mem_phase,
   output logic              rf_wr,
   output logic              retire,
   output logic              illegal,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
`ifdef SEQ_PERF_COUNTERS_EN
   output logic [31:0]       cycle_cnt,
   output logic [31:0]       retire_cnt,
`endif
   output logic              fault
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StHalt
   } state_e;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpHalt  = 6'h3F;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              fault_q, fault_d;
   logic [5:0]        opcode;
   state_e            boundary_state;

   assign opcode         = instr_q[31:26];
   // Instruction boundary: stop has priority over start.
   assign boundary_state = stop ? StIdle : StFetch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= ADDR_W'(PC_RESET);
         instr_q <= '0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      cnt_d     = cnt_q;
      fault_d   = fault_q;
      imem_req  = 1'b0;
      exec_en   = 1'b0;
      mem_phase = 1'b0;
      rf_wr     = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      busy      = 1'b1;
      halted    = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) state_d = StFetch;
         end
         StFetch: begin
            imem_req = 1'b1;
            // An ack in the timeout cycle still wins over the fault.
            if (imem_ack) begin
               instr_d = imem_rdata;
               cnt_d   = '0;
               state_d = StDecode;
            end else if (cnt_q == 8'(FETCH_TIMEOUT - 1)) begin
               cnt_d   = '0;
               fault_d = 1'b1;
               state_d = StHalt;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDecode: begin
            if (opcode == OpRtype || opcode == OpLw || opcode == OpSw) begin
               state_d = StExec;
            end else if (opcode == OpHalt) begin
               retire  = 1'b1;
               state_d = StHalt;
            end else begin
               illegal = 1'b1;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = boundary_state;
            end
         end
         StExec: begin
            exec_en = 1'b1;
            if (opcode == OpRtype) begin
               rf_wr   = 1'b1;
               retire  = 1'b1;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = boundary_state;
            end else begin
               state_d = StMem;
            end
         end
         StMem: begin
            mem_phase = 1'b1;
            if (cnt_q == 8'(MEM_WAIT - 1)) begin
               retire  = 1'b1;
               rf_wr   = (opcode == OpLw);
               pc_d    = pc_q + ADDR_W'(1);
               cnt_d   = '0;
               state_d = boundary_state;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StHalt: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign fault       = fault_q;

`ifdef SEQ_PERF_COUNTERS_EN
   logic [31:0] cycle_cnt_q, retire_cnt_q;

   // busy is low in HALT, so both counters freeze there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         if (busy) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt  = cycle_cnt_q;
   assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table, hand-written corner sequences and a
// randomized program checked against an instruction-level timing model.
module tb_instr_sequencer;

   localparam int MW = 2;
   localparam int FT = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req, exec_en, mem_phase, rf_wr, retire, illegal, busy, halted, fault;
   logic [7:0]  imem_addr, pc;
   logic [31:0] instruction;
`ifdef SEQ_PERF_COUNTERS_EN
   logic [31:0] cycle_cnt, retire_cnt;
`endif

   instr_sequencer #(
      .ADDR_W        (8),
      .PC_RESET      (0),
      .MEM_WAIT      (MW),
      .FETCH_TIMEOUT (FT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instruction (instruction),
      .exec_en     (exec_en),
      .mem_phase   (mem_phase),
      .rf_wr       (rf_wr),
      .retire      (retire),
      .illegal     (illegal),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted),
`ifdef SEQ_PERF_COUNTERS_EN
      .cycle_cnt   (cycle_cnt),
      .retire_cnt  (retire_cnt),
`endif
      .fault       (fault)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [31:0] imem [256];
   int          ack_lat = 0;
   int          waited = 0;
   int          last_ack_cyc = 0;
   bit          resp_en = 0;
   bit          rand_lat = 0;
   bit          spur = 0;

   typedef struct {
      logic [31:0] instr;
      int          exec_n;
      int          mem_n;
      int          rf_n;
      int          ret_n;
      int          ill_n;
      int          ret_d;
      logic [7:0]  pc_after;
      bit          halted_after;
   } vec_t;

   vec_t tv [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: sample outputs 1 unit after the edge, then play the memory for this cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (resp_en && imem_req) begin
         if (waited >= ack_lat) begin
            imem_ack     = 1'b1;
            imem_rdata   = imem[imem_addr];
            waited       = 0;
            last_ack_cyc = cyc;
            if (rand_lat) ack_lat = $urandom_range(0, 3);
         end else begin
            waited++;
         end
      end else if (spur && $urandom_range(0, 3) == 0) begin
         imem_ack = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      imem_ack = 1'b0;
      waited   = 0;
      ack_lat  = 0;
      resp_en  = 0;
      rand_lat = 0;
      spur     = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // 0 R-type, 1 lw, 2 sw, 3 illegal, 4 halt
   function automatic int kind_of(input logic [31:0] w);
      case (w[31:26])
         6'h00:   return 0;
         6'h23:   return 1;
         6'h2B:   return 2;
         6'h3F:   return 4;
         default: return 3;
      endcase
   endfunction

   // Last cycle of an instruction, counted from its fetch-ack cycle.
   function automatic int end_off(input int kind);
      if (kind == 0) return 2;
      if (kind == 3) return 1;
      return 2 + MW;
   endfunction

   // {req, exec_en, mem_phase, rf_wr, retire, illegal, busy, halted}
   function automatic logic [7:0] exp_vec(input bit fetching, input int kind, input int d);
      logic ex, mp, rt, rf, il;
      if (fetching) return 8'b1000_0010;
      ex = (kind <= 2) && (d == 2);
      mp = (kind == 1 || kind == 2) && (d >= 3) && (d <= 2 + MW);
      rt = (kind == 0 && d == 2) || ((kind == 1 || kind == 2) && d == 2 + MW);
      rf = rt && (kind <= 1);
      il = (kind == 3) && (d == 1);
      return {1'b0, ex, mp, rf, rt, il, 1'b1, 1'b0};
   endfunction

   function automatic logic [31:0] rand_word();
      logic [5:0] op;
      case ($urandom_range(0, 3))
         0: op = 6'h00;
         1: op = 6'h23;
         2: op = 6'h2B;
         default: begin
            op = 6'($urandom_range(1, 62));
            if (op == 6'h23 || op == 6'h2B) op = 6'h10;
         end
      endcase
      return {op, 26'($urandom)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          exec_n, mem_n, rf_n, ret_n, ill_n, ret_d, nreq, nret, ninstr, kind, ack_cyc;
      int          m_pc;
      bit          fetching, seen;
      logic [31:0] m_word;

      tv[0] = '{32'h012A4020, 1, 0, 1, 1, 0, 2, 8'h01, 1'b0};
      tv[1] = '{32'h8C080004, 1, 2, 1, 1, 0, 4, 8'h01, 1'b0};
      tv[2] = '{32'hAC080004, 1, 2, 0, 1, 0, 4, 8'h01, 1'b0};
      tv[3] = '{32'h08000000, 0, 0, 0, 0, 1, -1, 8'h01, 1'b0};
      tv[4] = '{32'h3C001234, 0, 0, 0, 0, 1, -1, 8'h01, 1'b0};
      tv[5] = '{32'hFC000000, 0, 0, 0, 1, 0, 1, 8'h00, 1'b1};
      for (int a = 0; a < 256; a++) imem[a] = 32'h0;

      // Asynchronous reset values, before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("reset_vec", 64'({imem_req, exec_en, mem_phase, rf_wr, retire, illegal, busy, halted,
                              fault}), 64'(0));
      check("reset_pc_instr", 64'({pc, imem_addr, instruction}), 64'(0));
      do_reset();
      for (int c = 0; c < 3; c++) begin
         tick();
         check("idle_hold", 64'({busy, imem_req, halted}), 64'(0));
      end

      // Single-instruction vectors, ack one cycle after req, stop held high throughout.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         imem[0] = tv[i].instr;
         resp_en = 1;
         ack_lat = 1;
         stop    = 1'b1;
         start   = 1'b1;
         exec_n = 0; mem_n = 0; rf_n = 0; ret_n = 0; ill_n = 0; ret_d = -1;
         last_ack_cyc = -100;
         for (int c = 0; c < 14; c++) begin
            tick();
            start  = 1'b0;
            exec_n += int'(exec_en);
            mem_n  += int'(mem_phase);
            rf_n   += int'(rf_wr);
            ret_n  += int'(retire);
            ill_n  += int'(illegal);
            if (retire && ret_d < 0) ret_d = cyc - last_ack_cyc;
            if (rf_wr && !retire) check($sformatf("vec%0d_rf_alone", i), 64'(rf_wr), 64'(0));
         end
         check($sformatf("vec%0d_counts", i),
               64'({4'(exec_n), 4'(mem_n), 4'(rf_n), 4'(ret_n), 4'(ill_n)}),
               64'({4'(tv[i].exec_n), 4'(tv[i].mem_n), 4'(tv[i].rf_n), 4'(tv[i].ret_n),
                    4'(tv[i].ill_n)}));
         check($sformatf("vec%0d_retire_lat", i), 64'(ret_d), 64'(tv[i].ret_d));
         check($sformatf("vec%0d_end", i), 64'({pc, halted, busy}),
               64'({tv[i].pc_after, tv[i].halted_after, 1'b0}));
      end

      // Halt opcode: later start toggles and acks change nothing.
      do_reset();
      imem[0] = 32'hFC000000;
      resp_en = 1;
      ack_lat = 1;
      start   = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      spur = 1;
      for (int c = 0; c < 8; c++) begin
         start = c[0];
         tick();
         check("halt_hold", 64'({halted, busy, imem_req, retire, fault, pc}),
               64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
      end

      // Fetch timeout: exactly FT request cycles, then sticky fault in HALT.
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      nreq  = 0;
      for (int c = 0; c < 30; c++) begin
         nreq += int'(imem_req);
         if (c == FT - 2) check("fault_early", 64'(fault), 64'(0));
         tick();
      end
      check("timeout_req_cycles", 64'(nreq), 64'(FT));
      check("timeout_fault", 64'({fault, halted, busy}), 64'(3'b110));

      // Ack arriving in the timeout cycle wins.
      do_reset();
      imem[0] = 32'h012A4020;
      resp_en = 1;
      ack_lat = FT - 1;
      stop    = 1'b1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      nret  = 0;
      for (int c = 0; c < 25; c++) begin
         nret += int'(retire);
         tick();
      end
      check("late_ack_wins", 64'({fault, halted, busy, pc, 4'(nret)}),
            64'({1'b0, 1'b0, 1'b0, 8'h01, 4'd1}));

      // stop raised mid-instruction is held off until the boundary.
      do_reset();
      imem[0] = 32'h012A4020;
      imem[1] = 32'h012A4020;
      resp_en = 1;
      ack_lat = 1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      seen  = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (imem_ack) stop = 1'b1;
         if (exec_en) begin
            seen = 1;
            check("stop_exec_retire", 64'({retire, rf_wr}), 64'(2'b11));
            tick();
            check("stop_idle", 64'({busy, imem_req, pc}), 64'({1'b0, 1'b0, 8'h01}));
         end
      end
      check("stop_seen_exec", 64'(seen), 64'(1));

      // Late ack outside FETCH, then asynchronous reset in the middle of MEM.
      do_reset();
      imem[0] = 32'h8C080004;
      resp_en = 1;
      ack_lat = 0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEADBEEF;
      tick();
      check("exec_instr_held", 64'({exec_en, instruction}), 64'({1'b1, 32'h8C080004}));
      tick();
      check("mem_entered", 64'(mem_phase), 64'(1));
      rst_n = 1'b0;
      #1;
      check("async_reset_vec", 64'({imem_req, exec_en, mem_phase, rf_wr, retire, illegal, busy,
                                    halted, fault}), 64'(0));
      check("async_reset_pc_instr", 64'({pc, instruction}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

`ifdef SEQ_PERF_COUNTERS_EN
      do_reset();
      for (int a = 0; a < 3; a++) imem[a] = 32'h012A4020;
      resp_en = 1;
      ack_lat = 1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      nret  = 0;
      for (int c = 0; c < 40 && nret < 3; c++) begin
         tick();
         if (retire) begin
            nret++;
            if (nret == 3) stop = 1'b1;
         end
      end
      tick();
      check("perf_counters", 64'({cycle_cnt, retire_cnt}), {32'd12, 32'd3});
`endif

      // Random program with random ack latency and stray acks; long enough for pc to wrap.
      do_reset();
      for (int a = 0; a < 256; a++) imem[a] = rand_word();
      resp_en  = 1;
      rand_lat = 1;
      spur     = 1;
      start    = 1'b1;
      fetching = 1;
      m_pc     = 0;
      ninstr   = 0;
      kind     = 0;
      ack_cyc  = 0;
      m_word   = '0;
      for (int c = 0; c < 6000 && ninstr < 400; c++) begin
         tick();
         if (!fetching && cyc - ack_cyc == end_off(kind) + 1) begin
            fetching = 1;
            m_pc     = (m_pc + 1) % 256;
         end
         check("rand_vec", 64'({imem_req, exec_en, mem_phase, rf_wr, retire, illegal, busy,
                                halted}), 64'(exp_vec(fetching, kind, cyc - ack_cyc)));
         if (fetching) check("rand_addr", 64'({imem_addr, pc}), 64'({8'(m_pc), 8'(m_pc)}));
         else check("rand_instr", 64'(instruction), 64'(m_word));
         if (fetching && imem_ack) begin
            fetching = 0;
            ack_cyc  = cyc;
            m_word   = imem[m_pc];
            kind     = kind_of(m_word);
            ninstr++;
         end
      end
      check("rand_instr_count", 64'(ninstr), 64'(400));
      stop = 1'b1;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         if (!busy) seen = 1;
      end
      check("rand_stop_idle", 64'(seen), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer that fetches 32-bit instructions from an instruction memory over a req/ack handshake.
- Presents each instruction, held stable, to the single-cycle datapath.
- Generates phase strobes: execute, memory phase, register-write, retire.
- Sits between instruction memory and the datapath; owns PC, halt and fault state.

Parameters:
ADDR_W, 8, PC / instruction-memory word-address width; PC wraps modulo 2^ADDR_W
PC_RESET, 0, PC value loaded on reset
MEM_WAIT, 1, cycles spent in MEM state for lw/sw (legal range 1..15)
FETCH_TIMEOUT, 15, max cycles waiting for imem_ack before fault (legal range 1..255)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level; leaves IDLE when high
stop  input  1  level; sampled at instruction boundary, returns to IDLE
imem_req  output  1  fetch request, held until ack
imem_addr  output  ADDR_W  fetch address (= pc)
imem_ack  input  1  one-cycle fetch acknowledge
imem_rdata  input  32  instruction word, valid when imem_ack=1
instruction  output  32  registered instruction to datapath
exec_en  output  1  high in EXEC state
mem_phase  output  1  high in MEM state
rf_wr  output  1  one-cycle register-write strobe (R-type, lw)
retire  output  1  one-cycle pulse per completed instruction
illegal  output  1  one-cycle pulse on unsupported opcode
pc  output  ADDR_W  current PC
busy  output  1  high in any state except IDLE and HALT
halted  output  1  high in HALT
fault  output  1  sticky fetch-timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=PC_RESET, instruction=0, fault=0, all strobes/req=0, timeout counter=0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: busy=0. start=1 → FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc; counter increments each cycle without ack.
  - imem_ack=1 → instruction<=imem_rdata, counter cleared, → DECODE.
  - counter reaches FETCH_TIMEOUT with no ack → HALT, fault<=1; ack in that same cycle wins (no fault).
- DECODE (1 cycle), opcode = instruction[31:26]:
  - 000000 (R-type), 100011 (lw), 101011 (sw) → EXEC.
  - 111111 (halt) → HALT; retire pulses; pc not advanced.
  - Any other opcode: illegal pulses, pc<=pc+1, then boundary rule.
- EXEC (1 cycle): exec_en=1.
  - R-type: rf_wr=1, retire=1, pc<=pc+1, then boundary rule.
  - lw/sw → MEM.
- MEM: mem_phase=1 for exactly MEM_WAIT cycles. On the last cycle: retire=1, rf_wr=1 only for lw, pc<=pc+1, then boundary rule.
- Boundary rule: stop=1 → IDLE; else → FETCH. stop is ignored mid-instruction. start and stop both high at a boundary → stop wins.
- HALT: busy=0, halted=1. Exits only via reset; start/stop ignored.
- instruction is held constant from DECODE through the end of EXEC/MEM.
- Latency from fetch ack to retire: R-type = 2 cycles (DECODE, EXEC); lw/sw = 2+MEM_WAIT.
- pc at 2^ADDR_W-1 increments to 0.
- A late imem_ack outside FETCH is ignored.
- Reset asserted mid-instruction: immediate return to reset values; no strobe is emitted.

Optional Feature:
- Macro SEQ_PERF_COUNTERS_EN.
- Defined: adds outputs cycle_cnt[31:0] and retire_cnt[31:0].
  - cycle_cnt counts every cycle with busy=1.
  - retire_cnt counts retire pulses.
  - Both reset to 0, wrap at 2^32, freeze in HALT.
- Not defined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset, pc=0. start=1, imem returns 0x012A4020 (R-type add) with ack 1 cycle after req → DECODE, EXEC; exec_en=1 one cycle; rf_wr=1 and retire=1 in the same cycle; pc=1; next state FETCH.
- lw 0x8C080004 with MEM_WAIT=2 → mem_phase high exactly 2 cycles; rf_wr=1 and retire=1 on the second; pc+1. Repeat with sw 0xAC080004 → retire=1, rf_wr=0.
- Opcode 0x3F (0xFC000000) → halted=1, busy=0, pc unchanged; later start toggles and acks cause no state change.
- Opcode 0x02 → illegal pulses once, no rf_wr/retire, pc advances, next FETCH at pc+1. Separately, withhold ack for 15 cycles → fault=1, halted=1.
- stop raised during EXEC of an R-type → retires normally, then IDLE with busy=0. pc=0xFF retire → pc=0x00. rst_n low mid-MEM → all outputs at reset values asynchronously.
- With SEQ_PERF_COUNTERS_EN defined: 3 R-type instructions with 1-cycle ack latency → retire_cnt=3, cycle_cnt=12 at the third retire.
